soc_system_dac_out: RTL
=======================

SOC_SYSTEM_DAC_OUT -- requirements
Module: soc_system_dac_out

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the output data path and registers.
REQ-002 SHALL have parameter RESET_VALUE, default 0, the value loaded into the shadow, out_data and out_port registers on reset.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is rising-edge clocked.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port address  input  2  Avalon-MM word address.
REQ-006 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-007 SHALL have port write_n  input  1  Avalon-MM write strobe, active-low; a write is chipselect=1 and write_n=0.
REQ-008 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-009 SHALL have port readdata  output  32  Avalon-MM read data, registered.
REQ-010 SHALL have port out_valid  output  1  an offered value is on out_data.
REQ-011 SHALL have port out_ready  input  1  downstream DAC serializer accepts out_data.
REQ-012 SHALL have port out_data  output  DATA_WIDTH  offered value, stable while out_valid=1.
REQ-013 SHALL have port out_port  output  DATA_WIDTH  last value accepted downstream.

Function
REQ-014 SHALL decode registers: 0 DATA, 1 STATUS, 2 OUTSET, 3 OUTCLEAR.
REQ-015 SHALL, on a DATA write, set shadow to writedata[DATA_WIDTH-1:0].
REQ-016 SHALL, on an OUTSET write, set shadow to shadow OR writedata.
REQ-017 SHALL, on an OUTCLEAR write, set shadow to shadow AND NOT writedata.
REQ-018 SHALL, on any write to address 0, 2 or 3, set pending=1 one cycle after the write edge.
REQ-019 SHALL set sticky overrun=1 when a write to address 0, 2 or 3 occurs while pending=1 and no capture occurs on that edge.
REQ-020 SHALL clear overrun on a STATUS write with writedata[1]=1; a simultaneous overrun set wins.
REQ-021 SHALL register readdata every cycle with no wait states: address 0 gives shadow, zero-extended; address 1 gives {29'b0, busy, overrun, pending}, where busy = state OFFER; addresses 2 and 3 give 0.
REQ-022 SHALL implement FSM IDLE/OFFER: IDLE with pending=1 -> OFFER on the next edge, capturing out_data<=shadow and clearing pending.
REQ-023 SHALL drive out_valid=1 exactly while in OFFER, holding out_data stable.
REQ-024 SHALL, in OFFER with out_ready=1, load out_port<=out_data and return to IDLE on that edge.
REQ-025 SHALL ignore out_ready while in IDLE.
REQ-026 SHALL, on a write coinciding with the capture edge, capture the pre-write shadow, set pending=1 again and not set overrun.
REQ-027 SHALL, on a write during OFFER, update shadow and set pending without altering out_data; a re-offer follows via IDLE.
REQ-028 SHALL make out_valid high two edges after the write edge (write edge k, pending after k, out_valid after k+1) and update out_port on the accept edge.

Reset
REQ-029 SHALL, on reset, asynchronously force readdata=0, shadow=out_data=out_port=RESET_VALUE, out_valid=0, pending=0, overrun=0 and state=IDLE.
REQ-030 SHALL, on reset mid-OFFER, abandon the transfer and leave out_port at RESET_VALUE.
REQ-031 SHALL resume normal operation on the first edge after reset deasserts.

Structure
REQ-032 SHALL place the address constants, STATUS bit indices and the IDLE/OFFER state encoding in the shared package soc_system_dac_out_pkg.
REQ-033 SHALL contain one sub-module, soc_system_dac_out_xfer, holding the FSM, out_data, out_valid and out_port; the register decode stays in the top.

Verification
REQ-034 SHALL verify: DATA write 0x0000_1234, out_ready=1 -> out_valid high 2 edges after the write, out_port=0x1234 on the next edge, STATUS reads 0.
REQ-035 SHALL verify: DATA 0x00F0, then OUTSET 0x000F, then OUTCLEAR 0x0030 -> DATA reads 0x00CF and the final out_port is 0x00CF.
REQ-036 SHALL verify: out_ready=0, DATA writes 0xA, then 0xB while pending -> STATUS overrun=1; after release, out_port sequence is 0xA then 0xB, or only the latest per the capture timing; a STATUS write of 0x2 clears overrun.
REQ-037 SHALL verify: a write on the capture edge -> old value offered, pending=1, overrun=0, followed by a second offer of the new value.
REQ-038 SHALL verify: reset asserted mid-OFFER with out_ready=0 -> out_valid=0 immediately and out_port=RESET_VALUE; no stale offer after deassert.
REQ-039 SHALL verify: a read of address 2 or 3 -> readdata=0 one cycle later, with no change to shadow.

Source files
------------

// File: rtl/soc_system_dac_out_pkg.sv
// Shared constants for the DAC output register block:
// register map, STATUS bit positions and transfer FSM states.
package soc_system_dac_out_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_OUTSET   = 2'd2;
  localparam logic [1:0] ADDR_OUTCLEAR = 2'd3;

  localparam int ST_PENDING = 0;
  localparam int ST_OVERRUN = 1;
  localparam int ST_BUSY    = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } xfer_state_t;

endpackage

// File: rtl/soc_system_dac_out_xfer.sv
// Offer/accept handshake towards the DAC serializer.
// Holds the offered value and the last accepted value.
module soc_system_dac_out_xfer
  import soc_system_dac_out_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pending,
  input  logic [DATA_WIDTH-1:0] shadow,
  input  logic                  out_ready,
  output logic                  capture,
  output logic                  busy,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0] out_port
);

  xfer_state_t state;
  xfer_state_t state_nx;
  logic        accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      out_data <= RESET_VALUE;
      out_port <= RESET_VALUE;
    end else begin
      state <= state_nx;
      if (capture) out_data <= shadow;
      if (accept)  out_port <= out_data;
    end
  end

  // out_ready is only looked at while an offer is on the bus
  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pending) begin
          capture  = 1'b1;
          state_nx = OFFER;
        end
      end
      OFFER: begin
        if (out_ready) begin
          accept   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign out_valid = (state == OFFER);
  assign busy      = out_valid;

endmodule

// File: rtl/soc_system_dac_out.sv
// Avalon-MM register front end for the DAC output path:
// shadow register, pending/overrun tracking and readback.
module soc_system_dac_out
  import soc_system_dac_out_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic [DATA_WIDTH-1:0] shadow;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  pending;
  logic                  overrun;
  logic                  capture;
  logic                  busy;
  logic                  wr;
  logic                  wr_out;
  logic                  ovr_set;
  logic                  ovr_clr;
  logic [31:0]           status;

  assign wdata   = writedata[DATA_WIDTH-1:0];
  assign wr      = chipselect & ~write_n;
  assign wr_out  = wr & (address != ADDR_STATUS);
  // a write landing on the capture edge re-arms pending, not overrun
  assign ovr_set = wr_out & pending & ~capture;
  assign ovr_clr = wr & (address == ADDR_STATUS)
                 & writedata[ST_OVERRUN];

  always_comb begin
    status             = '0;
    status[ST_PENDING] = pending;
    status[ST_OVERRUN] = overrun;
    status[ST_BUSY]    = busy;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow   <= RESET_VALUE;
      pending  <= 1'b0;
      overrun  <= 1'b0;
      readdata <= '0;
    end else begin
      if (wr) begin
        unique case (address)
          ADDR_DATA:     shadow <= wdata;
          ADDR_OUTSET:   shadow <= shadow | wdata;
          ADDR_OUTCLEAR: shadow <= shadow & ~wdata;
          default:       ;
        endcase
      end
      if (wr_out)       pending <= 1'b1;
      else if (capture) pending <= 1'b0;
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
      unique case (address)
        ADDR_DATA:   readdata <= 32'(shadow);
        ADDR_STATUS: readdata <= status;
        default:     readdata <= '0;
      endcase
    end
  end

  soc_system_dac_out_xfer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_xfer (
    .clk       (clk),
    .reset     (reset),
    .pending   (pending),
    .shadow    (shadow),
    .out_ready (out_ready),
    .capture   (capture),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_port  (out_port)
  );

endmodule
